// File: rtl/enc_daq_pkg.sv
// Shared definitions for the encoder DAQ path: FSM states, flag offsets, defaults.
// Flag offsets are relative to DELTA_W, so FIRST sits at bit DELTA_W+1 and SAT at DELTA_W.
// No logic lives here; types and constants only.
package enc_daq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int FLAG_FIRST_OFS = 1;
  localparam int FLAG_SAT_OFS   = 0;

  localparam int DEF_DELTA_W = 32;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_DROP_W  = 16;

endpackage

// File: rtl/enc_sfifo.sv
// Generic synchronous show-ahead FIFO with sync active-low reset and sync clear.
// Latency: a word pushed at an edge is visible at o_head after that edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module enc_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; array is not reset, occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clr && w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
  end

  // Pointer update; reset and clear both empty the queue.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/enc_period_fifo.sv
// Captures the encoder count on each phase-A rise and queues {FIRST,SAT,delta} words.
// Latency: rise seen at edge t, count sampled at t+1, word pushed at t+2.
// Backpressure: valid/ready stream; pushes into a full FIFO are dropped and counted.
module enc_period_fifo
  import enc_daq_pkg::*;
#(
  parameter int DELTA_W = DEF_DELTA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int DROP_W  = DEF_DROP_W
) (
  input  logic                   CLK,
  input  logic                   I_RST_N,
  input  logic                   I_ARM,
  input  logic                   I_A,
  input  logic [63:0]            I_CNT,
  input  logic                   I_READY,
  output logic                   O_VALID,
  output logic [DELTA_W+1:0]     O_DATA,
  output logic [$clog2(DEPTH):0] O_LEVEL,
  output logic [DROP_W-1:0]      O_DROP_CNT
);

  state_t             r_state;
  logic               r_a_d;
  logic               r_cap_pend;
  logic               r_push_vld;
  logic [DELTA_W+1:0] r_push_dat;
  logic [63:0]        r_prev;
  logic [DROP_W-1:0]  r_drop_cnt;

  logic               w_rise;
  logic               w_clr;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_drop;
  logic [63:0]        w_diff;
  logic               w_sat;
  logic [DELTA_W+1:0] w_word;

  assign w_rise  = I_A & ~r_a_d;
  assign w_clr   = ~I_ARM;
  assign O_VALID = ~w_empty;
  assign w_pop   = O_VALID & I_READY;
  assign w_drop  = r_push_vld & w_full & ~w_pop;

  // Delta against the previous capture; prev is zero in WAIT, but select explicitly.
  assign w_diff = (r_state == ST_RUN) ? (I_CNT - r_prev) : I_CNT;
  assign w_sat  = ((w_diff >> DELTA_W) != 64'd0);

  // Assemble the output word: saturated delta plus FIRST/SAT flags.
  always_comb begin
    w_word = '0;
    w_word[DELTA_W-1:0] = w_sat ? {DELTA_W{1'b1}} : w_diff[DELTA_W-1:0];
    w_word[DELTA_W+FLAG_SAT_OFS]   = w_sat;
    w_word[DELTA_W+FLAG_FIRST_OFS] = (r_state == ST_WAIT);
  end

  // Edge detect, capture pipeline and IDLE/WAIT/RUN control; disarm clears like reset.
  always_ff @(posedge CLK) begin
    if (!I_RST_N || !I_ARM) begin
      r_state    <= ST_IDLE;
      r_a_d      <= 1'b0;
      r_cap_pend <= 1'b0;
      r_push_vld <= 1'b0;
      r_push_dat <= '0;
      r_prev     <= '0;
    end else begin
      r_a_d      <= I_A;
      r_cap_pend <= w_rise;
      r_push_vld <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_WAIT;
        ST_WAIT: begin
          // A zero count means the index has not been seen yet.
          if (r_cap_pend && (I_CNT != 64'd0)) begin
            r_state    <= ST_RUN;
            r_prev     <= I_CNT;
            r_push_vld <= 1'b1;
            r_push_dat <= w_word;
          end
        end
        ST_RUN: begin
          // Non-increasing counts are discarded but still become the new reference.
          if (r_cap_pend) begin
            r_prev <= I_CNT;
            if (I_CNT > r_prev) begin
              r_push_vld <= 1'b1;
              r_push_dat <= w_word;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of words lost to a full FIFO.
  always_ff @(posedge CLK) begin
    if (!I_RST_N || !I_ARM) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign O_DROP_CNT = r_drop_cnt;

  enc_sfifo #(
    .WIDTH (DELTA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (CLK),
    .i_rst_n    (I_RST_N),
    .i_clr      (w_clr),
    .i_push     (r_push_vld),
    .i_push_dat (r_push_dat),
    .i_pop      (w_pop),
    .o_head     (O_DATA),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (O_LEVEL)
  );

endmodule
